// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC and issues one word read at a time.
// Returned instructions and their PC+4 are buffered in a small FIFO for decode.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect,
    input  logic [W-1:0] redirect_pc,
    input  logic         deq,
    output logic         out_valid,
    output logic [W-1:0] out_inst,
    output logic [W-1:0] out_pc_plus4,
    output logic         mem_req,
    output logic [W-1:0] mem_addr,
    input  logic         mem_ack,
    input  logic [W-1:0] mem_rdata
);

    localparam int unsigned       PtrW      = $clog2(DEPTH);
    localparam logic [PtrW:0]     CountFull = (PtrW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

    state_e          stateQ, stateD;
    logic [W-1:0]    fetchPcQ, fetchPcD;
    logic            memReqQ, memReqD;
    logic [W-1:0]    memAddrQ, memAddrD;
    logic [PtrW-1:0] rdPtrQ, rdPtrD;
    logic [PtrW-1:0] wrPtrQ, wrPtrD;
    logic [PtrW:0]   countQ, countD;

    logic [W-1:0]    instMem [DEPTH];
    logic [W-1:0]    pcMem   [DEPTH];

    logic [W-1:0]    target;
    logic [W-1:0]    addrPlus4;
    logic [PtrW:0]   countAfterPush;
    logic            pop;
    logic            push;
    logic            flush;

    assign target         = {redirect_pc[W-1:2], 2'b00};
    assign addrPlus4      = memAddrQ + W'(4);
    assign pop            = deq & (countQ != '0) & ~redirect;
    assign countAfterPush = countQ + (PtrW + 1)'(1) - (PtrW + 1)'(pop);

    always_comb begin
        stateD   = stateQ;
        fetchPcD = fetchPcQ;
        memReqD  = memReqQ;
        memAddrD = memAddrQ;
        flush    = 1'b0;
        push     = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (redirect) begin
                    flush    = 1'b1;
                    fetchPcD = target;
                end else if (countQ < CountFull) begin
                    stateD   = StReq;
                    memReqD  = 1'b1;
                    memAddrD = fetchPcQ;
                end
            end
            StReq: begin
                if (mem_ack) begin
                    if (redirect) begin
                        flush    = 1'b1;
                        fetchPcD = target;
                        memAddrD = target;
                    end else begin
                        push     = 1'b1;
                        fetchPcD = addrPlus4;
                        if (countAfterPush < CountFull) begin
                            memAddrD = addrPlus4;
                        end else begin
                            stateD  = StIdle;
                            memReqD = 1'b0;
                        end
                    end
                end else if (redirect) begin
                    // Request cannot be withdrawn; wait out its ack and discard the data.
                    flush    = 1'b1;
                    fetchPcD = target;
                    stateD   = StDrop;
                end
            end
            StDrop: begin
                if (redirect) begin
                    flush    = 1'b1;
                    fetchPcD = target;
                end
                if (mem_ack) begin
                    stateD   = StReq;
                    memAddrD = redirect ? target : fetchPcQ;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        rdPtrD = rdPtrQ;
        wrPtrD = wrPtrQ;
        countD = countQ;
        if (flush) begin
            rdPtrD = '0;
            wrPtrD = '0;
            countD = '0;
        end else begin
            if (push) wrPtrD = wrPtrQ + PtrW'(1);
            if (pop)  rdPtrD = rdPtrQ + PtrW'(1);
            countD = countQ + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= StIdle;
            fetchPcQ <= '0;
            memReqQ  <= 1'b0;
            memAddrQ <= '0;
            rdPtrQ   <= '0;
            wrPtrQ   <= '0;
            countQ   <= '0;
        end else begin
            stateQ   <= stateD;
            fetchPcQ <= fetchPcD;
            memReqQ  <= memReqD;
            memAddrQ <= memAddrD;
            rdPtrQ   <= rdPtrD;
            wrPtrQ   <= wrPtrD;
            countQ   <= countD;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instMem[wrPtrQ] <= mem_rdata;
            pcMem[wrPtrQ]   <= addrPlus4;
        end
    end

    assign out_valid    = (countQ != '0);
    assign out_inst     = out_valid ? instMem[rdPtrQ] : '0;
    assign out_pc_plus4 = out_valid ? pcMem[rdPtrQ] : '0;
    assign mem_req      = memReqQ;
    assign mem_addr     = memAddrQ;

endmodule
